// File: rtl/minirisc_sequencer_if.sv
// Control/status bundle between the tile I/O decode, the sequencer and the accumulator datapath.
// slave: the sequencer side (loads program, consumes zero flag, drives ALU controls and status).
// master: the tile side that drives loads/start/enable and observes the controls.
interface minirisc_sequencer_if;
  logic       ena;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic       acc_zero;
  logic [2:0] alu_op;
  logic [3:0] operand;
  logic       acc_we;
  logic       out_strobe;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] pc_out;
  logic [3:0] state_out;

  modport slave (
    input  ena, prog_we, prog_addr, prog_data, start, acc_zero,
    output alu_op, operand, acc_we, out_strobe, busy, done, err, pc_out, state_out
  );

  modport master (
    output ena, prog_we, prog_addr, prog_data, start, acc_zero,
    input  alu_op, operand, acc_we, out_strobe, busy, done, err, pc_out, state_out
  );
endinterface

// File: rtl/minirisc_sequencer.sv
// Program buffer plus fetch/decode/execute controller for the minirisc accumulator datapath.
// Latency: start edge N -> FETCH N+1, DECODE N+2, EXEC N+3; one instruction every 3 cycles.
// Backpressure: ena=0 freezes every register and masks the acc_we/out_strobe pulses.
module minirisc_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int WDOG_MAX   = 255
) (
  input logic                 clk,
  input logic                 rst,
  minirisc_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_HALT   = 4'd4,
    S_ERROR  = 4'd5
  } state_e;

  localparam logic [7:0] WDOG_LIM = 8'(WDOG_MAX);

  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_OUT  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] wdog_q, wdog_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [3:0] operand_q, operand_d;
  logic       exe_we_q, exe_we_d;
  logic       exe_out_q, exe_out_d;

  logic [7:0] mem_q [PROG_DEPTH];
  logic       mem_wr;

  logic [3:0] opcode;
  logic [3:0] imm;
  logic [3:0] pc_inc;
  logic [7:0] wdog_inc;
  logic       exec_fire;

  assign opcode   = ir_q[7:4];
  assign imm      = ir_q[3:0];
  assign pc_inc   = pc_q + 4'd1;
  assign wdog_inc = wdog_q + 8'd1;

  // State, PC, IR, watchdog and decoded-control registers; ena=0 is handled by _d holding _q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      wdog_q    <= '0;
      alu_op_q  <= '0;
      operand_q <= '0;
      exe_we_q  <= 1'b0;
      exe_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      wdog_q    <= wdog_d;
      alu_op_q  <= alu_op_d;
      operand_q <= operand_d;
      exe_we_q  <= exe_we_d;
      exe_out_q <= exe_out_d;
    end
  end

  // Program buffer: cleared to NOPs on reset, written only when the FSM is not running.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PROG_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_wr) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Next-state logic: launch, fetch, decode, execute and watchdog; everything holds when ena=0.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    wdog_d    = wdog_q;
    alu_op_d  = alu_op_q;
    operand_d = operand_q;
    exe_we_d  = exe_we_q;
    exe_out_d = exe_out_q;
    mem_wr    = 1'b0;

    if (bus.ena) begin
      case (state_q)
        S_IDLE, S_HALT, S_ERROR: begin
          // start outranks a same-cycle program write
          if (bus.start) begin
            state_d = S_FETCH;
            pc_d    = '0;
            wdog_d  = '0;
          end else if (bus.prog_we) begin
            mem_wr = 1'b1;
          end
        end

        S_FETCH: begin
          ir_d    = mem_q[pc_q];
          state_d = S_DECODE;
        end

        S_DECODE: begin
          operand_d = imm;
          exe_out_d = (opcode == OP_OUT);
          case (opcode)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
              // LDI..XORI map onto ALU codes 0..5 in opcode order
              alu_op_d = opcode[2:0] - 3'd1;
              exe_we_d = 1'b1;
            end
            default: begin
              alu_op_d = 3'd0;
              exe_we_d = 1'b0;
            end
          endcase
          state_d = S_DECODE == state_q ? S_EXEC : state_q;
        end

        S_EXEC: begin
          wdog_d  = wdog_inc;
          state_d = S_FETCH;
          pc_d    = pc_inc;
          case (opcode)
            OP_JMP:  pc_d = imm;
            OP_JZ:   pc_d = bus.acc_zero ? imm : pc_inc;
            OP_HALT: begin
              state_d = S_HALT;
              pc_d    = pc_q;
            end
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin
              state_d = S_ERROR;
              pc_d    = pc_q;
            end
            default: ;
          endcase
          // runaway program: the limiting instruction still completes, then we stop
          if ((wdog_inc == WDOG_LIM) && (opcode != OP_HALT)) begin
            state_d = S_ERROR;
          end
        end

        default: state_d = S_ERROR;
      endcase
    end
  end

  // Execute pulses exist only in an enabled, non-reset EXEC cycle.
  assign exec_fire      = bus.ena && !rst && (state_q == S_EXEC);
  assign bus.acc_we     = exec_fire && exe_we_q;
  assign bus.out_strobe = exec_fire && exe_out_q;

  assign bus.alu_op     = alu_op_q;
  assign bus.operand    = operand_q;
  assign bus.pc_out     = pc_q;
  assign bus.state_out  = state_q;

  // Status purely from registered state.
  assign bus.busy = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign bus.done = (state_q == S_HALT);
  assign bus.err  = (state_q == S_ERROR);

endmodule

// File: doc/minirisc_sequencer.md
# minirisc_sequencer

Program buffer and fetch/decode/execute controller for the minirisc accumulator datapath. Holds a 16-entry, 8-bit program loaded over a simple write port and sequences it one instruction per three cycles. For each instruction it drives the accumulator's ALU-op, immediate and write-enable controls, and it resolves branches from the datapath's zero flag. It sits between the tile I/O decode and the accumulator/ALU, and exports `state_out` and `pc_out` for debug.

## Interface
- `PROG_DEPTH`, 16, program buffer entries; fixed at 16 for the 4-bit PC.
- `WDOG_MAX`, 255, maximum number of executed instructions before forced error.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ena` in 1: low freezes FSM, PC, counters and buffer writes; outputs hold.
- `prog_we` in 1: program write strobe.
- `prog_addr` in 4: program write address.
- `prog_data` in 8: program word, `[7:4]` opcode, `[3:0]` imm.
- `start` in 1: launch execution at PC=0.
- `acc_zero` in 1: datapath accumulator == 0.
- `alu_op` out 3: 0 pass imm, 1 add, 2 sub, 3 and, 4 or, 5 xor.
- `operand` out 4: immediate for the ALU.
- `acc_we` out 1: accumulator write pulse.
- `out_strobe` out 1: latch accumulator to `uo_out`.
- `busy` out 1: FSM in FETCH/DECODE/EXEC.
- `done` out 1: FSM in HALT.
- `err` out 1: FSM in ERROR.
- `pc_out` out 4: current PC.
- `state_out` out 4: FSM state code.

## Operation
- **States and codes:** IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4, ERROR=5. Codes 6–15 are unused; if reached, go to ERROR.
- **Program loading:**
  - `prog_we` writes `mem[prog_addr]<=prog_data` only in IDLE, HALT or ERROR.
  - `prog_we` is ignored in FETCH/DECODE/EXEC.
  - `rst` clears all 16 entries to 0x00 (NOP).
- **Start:** `start` in IDLE, HALT or ERROR sets PC=0, clears the watchdog count and enters FETCH. `start` is ignored while busy.
- **FETCH:** IR<=mem[PC]; go to DECODE.
- **DECODE:** register `alu_op`, `operand` and the execute flags from IR; go to EXEC.
- **EXEC:** perform the instruction's action, then the next state is FETCH unless stated otherwise. Opcode behaviour:
  - 0 NOP: PC+1.
  - 1 LDI: `alu_op`=0, `acc_we`.
  - 2 ADDI: `alu_op`=1, `acc_we`.
  - 3 SUBI: `alu_op`=2, `acc_we`.
  - 4 ANDI: `alu_op`=3, `acc_we`.
  - 5 ORI: `alu_op`=4, `acc_we`.
  - 6 XORI: `alu_op`=5, `acc_we`.
  - Opcodes 1–6 all advance PC+1.
  - 7 JMP: PC<=imm.
  - 8 JZ: PC<=imm if `acc_zero`, else PC+1; `acc_zero` is sampled in EXEC.
  - 9 OUT: `out_strobe`, PC+1.
  - F HALT: go to HALT; PC holds.
  - A–E illegal: go to ERROR; PC holds.
- **PC arithmetic:** 4-bit unsigned; 15+1 wraps to 0.
- **Watchdog:** an 8-bit counter increments on every EXEC. If it reaches `WDOG_MAX` on a non-HALT instruction, go to ERROR instead of FETCH; that instruction's `acc_we`/`out_strobe` still fire.
- **Output pulses:** `acc_we` and `out_strobe` are high only in the EXEC cycle. `alu_op`/`operand` are stable from DECODE+1 until the next DECODE.
- **ena:** `ena`=0 holds every register. `acc_we`/`out_strobe` are forced 0 while `ena`=0. EXEC resumes when `ena` returns high.
- **Priority:** `rst` > `ena`=0 > `start` > `prog_we`.

## Timing
- **Reset:** all outputs 0, `state_out`=0, PC=0, IR=0, watchdog=0, buffer cleared.
- **Launch:** `start` sampled at edge N gives FETCH in cycle N+1, DECODE N+2, EXEC N+3; next FETCH N+4.
- **Throughput:** 3 cycles per instruction. A program of k instructions ending in HALT raises `done` k·3 cycles after the `start` edge.
- **Status outputs:** `busy`/`done`/`err` are decoded from registered state, so they have no combinational path from inputs.
- **Reset mid-run:** returns to IDLE with no `acc_we` pulse in the reset cycle.

## Test plan
- **Straight-line program:** load 0x15, 0x23, 0x90, 0xF0; `start` → `acc_we` in EXEC of instr 0 (`alu_op`=0, `operand`=5) and instr 1 (`alu_op`=1, `operand`=3), `out_strobe` once, `done` at cycle 12 after start, `busy` high 12 cycles.
- **Branch:** load 0x10, 0x83, 0x9F, 0xF0 with `acc_zero`=1 → PC goes 0,1,3, halts without `out_strobe`. Rerun with `acc_zero`=0 → `out_strobe` fires, PC goes 0,1,2,3.
- **Illegal and unused codes:**
  - Load 0xA0 at addr 0 → `err`=1, `state_out`=5, PC=0, no `acc_we`.
  - `start` → rerun from PC=0.
  - Unused state codes are not directly stimulable; check them by inspection/assertion.
- **Watchdog:** load 0x70 (JMP 0) → `err` after exactly 255 EXECs (765 cycles after start). PC wrap check: 15 NOPs then 0x00 at addr 15 shows PC 15→0.
- **Write gating and ena:**
  - `prog_we` during EXEC leaves the buffer unchanged.
  - `ena`=0 for 5 cycles mid-DECODE → state and PC hold, no pulses; completion is delayed by exactly 5 cycles.
- **Reset mid-run:** `rst` during EXEC of ADDI → next cycle `state_out`=0, all outputs 0, buffer reads 0x00.
